// File: rtl/mux_arb_pkg.sv
// Package mux_arb_pkg
// Shared definitions for the two-requester round-robin mux arbiter:
//   - arbiter state encoding (IDLE / OWN0 / OWN1)
//   - one-hot grant constants
//   - default stream data width
//   - small helpers mapping state <-> grant / owner index
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_REQ0 = 2'b01;
  localparam logic [1:0] GRANT_REQ1 = 2'b10;

  localparam int DEFAULT_WIDTH = 8;

  // One-hot grant presented for a given state.
  function automatic logic [1:0] grant_of(input arb_state_e s);
    logic [1:0] g;
    g = GRANT_NONE;
    case (s)
      ST_OWN0: g = GRANT_REQ0;
      ST_OWN1: g = GRANT_REQ1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

  // Ownership state for requester index 'who'.
  function automatic arb_state_e own_state(input logic who);
    return who ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mux_2x1_w.sv
// Module mux_2x1_w
// Plain W-bit 2:1 multiplexer. The arbiter uses it over the packed
// {valid, last, data} bundle of each requester.
// Ports:
//   sel    in  1   0 -> in0, 1 -> in1
//   in0    in  W   requester 0 bundle
//   in1    in  W   requester 1 bundle
//   out_y  out W   selected bundle
module mux_2x1_w #(
  parameter int W = 10
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out_y
);

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign out_y[gi] = sel ? in1[gi] : in0[gi];
    end
  endgenerate

endmodule

// File: rtl/mux_2x1_rr_arbiter.sv
// Module mux_2x1_rr_arbiter
// Two-requester round-robin arbiter/sequencer for a shared 2:1 data mux.
// Forwards the granted requester's valid/data/last stream to one consumer
// over a valid/ready handshake and holds the grant for a whole packet.
//
// Optional feature (compile-time macro ARB_BURST_LIMIT_EN):
//   defined     -> a beat counter forces a grant handoff after MAX_BURST
//                  beats when the other requester is waiting
//   not defined -> grant held strictly until the last beat; MAX_BURST unused
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   valid0/1   in   1      requester has a beat
//   data0/1    in   WIDTH  requester data
//   last0/1    in   1      requester final beat of packet
//   ready0/1   out  1      requester beat accepted this cycle
//   out_valid  out  1      output beat valid
//   out_data   out  WIDTH  muxed data
//   out_last   out  1      muxed last
//   out_ready  in   1      consumer accepts beat
//   grant      out  2      one-hot owner, 00 when idle
//   sel        out  1      registered mux select, keeps last owner while idle
module mux_2x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  output logic             ready0,
  input  logic             valid1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic             ready1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       grant,
  output logic             sel
);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("mux_2x1_rr_arbiter: MAX_BURST must be >= 1");
  end

  arb_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic       prio_q, prio_d;   // last requester to finish; the other wins ties

  logic [WIDTH+1:0] mux_in0, mux_in1, mux_out;
  logic             owner_valid, owner_last, other_valid;
  logic             owning, xfer, force_release, pkt_release, idle_winner;

  assign mux_in0 = {valid0, last0, data0};
  assign mux_in1 = {valid1, last1, data1};

  mux_2x1_w #(.W(WIDTH + 2)) u_mux (
    .sel   (sel_q),
    .in0   (mux_in0),
    .in1   (mux_in1),
    .out_y (mux_out)
  );

  assign owner_valid = mux_out[WIDTH+1];
  assign owner_last  = mux_out[WIDTH];
  // sel_q always names the owner while a grant is active.
  assign other_valid = sel_q ? valid0 : valid1;
  assign owning      = (state_q != ST_IDLE);

  // Handshake outputs are masked during reset so no beat moves in that cycle.
  assign out_valid = owning & owner_valid & ~rst;
  assign out_last  = owning & owner_last;
  assign out_data  = mux_out[WIDTH-1:0];
  assign ready0    = (state_q == ST_OWN0) & out_ready & ~rst;
  assign ready1    = (state_q == ST_OWN1) & out_ready & ~rst;
  assign grant     = grant_of(state_q);
  assign sel       = sel_q;

  assign xfer        = out_valid & out_ready;
  assign pkt_release = xfer & (owner_last | force_release);

  // Tie from idle goes to the requester that did not finish most recently.
  assign idle_winner = (valid0 & valid1) ? ~prio_q : valid1;

`ifdef ARB_BURST_LIMIT_EN
  localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter saturates at CNT_LAST so an owner that runs past the limit
  // with nobody waiting is still cut off as soon as the other side asks.
  assign force_release = xfer & other_valid & (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (pkt_release) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_release = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (valid0 | valid1) begin
          sel_d   = idle_winner;
          state_d = own_state(idle_winner);
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (pkt_release) begin
          prio_d = sel_q;
          if (other_valid) begin
            // Direct handoff on the same edge: no idle bubble.
            sel_d   = ~sel_q;
            state_d = own_state(~sel_q);
          end else if (owner_valid) begin
            // The finishing owner is still valid on the release edge, so with
            // no competitor it keeps the grant for its next packet.
            state_d = own_state(sel_q);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Testbench for mux_2x1_rr_arbiter: queue-based producers, a per-cycle
// behavioural reference, and hand-computed transfer logs per scenario.
// Works with or without ARB_BURST_LIMIT_EN (MAX_BURST fixed to 2 here).
module tb_mux_2x1_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 2;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid0, last0, valid1, last1, out_ready;
  logic [WIDTH-1:0] data0, data1, out_data;
  logic             ready0, ready1, out_valid, out_last, sel;
  logic [1:0]       grant;

  always #5 clk = ~clk;

  mux_2x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid0    (valid0),
    .data0     (data0),
    .last0     (last0),
    .ready0    (ready0),
    .valid1    (valid1),
    .data1     (data1),
    .last1     (last1),
    .ready1    (ready1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel)
  );

  beat_t q0[$];
  beat_t q1[$];
  int    log_src[$];
  int    log_data[$];
  int    log_cyc[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  logic  acc0 = 1'b0;
  logic  acc1 = 1'b0;

  // Reference state: who owns the port (-1 none), whose turn it is to lose
  // a tie, the registered select, and beats moved in the current grant.
  int m_owner = -1;
  int m_ptr   = 1;
  int m_sel   = 0;
  int m_beats = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int who, input logic [WIDTH-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    if (who == 0) q0.push_back(b);
    else          q1.push_back(b);
  endtask

  task automatic drive_inputs();
    valid0 = (q0.size() != 0);
    data0  = (q0.size() != 0) ? q0[0].data : '0;
    last0  = (q0.size() != 0) ? q0[0].last : 1'b0;
    valid1 = (q1.size() != 0);
    data1  = (q1.size() != 0) ? q1[0].data : '0;
    last1  = (q1.size() != 0) ? q1[0].last : 1'b0;
  endtask

  // Compare DUT against the reference, then advance the reference using the
  // inputs that the coming rising edge will sample.
  task automatic compare_and_model();
    int v[2];
    int l[2];
    int d[2];
    int exp_ov, exp_r0, exp_r1, exp_grant, x;
    bit rel;
    v[0] = int'(valid0); v[1] = int'(valid1);
    l[0] = int'(last0);  l[1] = int'(last1);
    d[0] = int'(data0);  d[1] = int'(data1);

    exp_grant = (m_owner == 0) ? 1 : (m_owner == 1) ? 2 : 0;
    exp_ov    = (!rst && m_owner >= 0 && v[m_owner] != 0) ? 1 : 0;
    exp_r0    = (!rst && m_owner == 0 && out_ready) ? 1 : 0;
    exp_r1    = (!rst && m_owner == 1 && out_ready) ? 1 : 0;

    chk("cyc_grant", 32'(grant), 32'(exp_grant));
    chk("cyc_sel", 32'(sel), 32'(m_sel));
    chk("cyc_out_valid", 32'(out_valid), 32'(exp_ov));
    chk("cyc_ready0", 32'(ready0), 32'(exp_r0));
    chk("cyc_ready1", 32'(ready1), 32'(exp_r1));
    if (exp_ov != 0) begin
      chk("cyc_out_data", 32'(out_data), 32'(d[m_owner]));
      chk("cyc_out_last", 32'(out_last), 32'(l[m_owner]));
    end

    acc0 = valid0 & ready0;
    acc1 = valid1 & ready1;
    if (out_valid && out_ready) begin
      log_src.push_back(ready1 ? 1 : 0);
      log_data.push_back(int'(out_data));
      log_cyc.push_back(cyc);
    end
    cyc++;

    if (rst) begin
      m_owner = -1; m_ptr = 1; m_sel = 0; m_beats = 0;
    end else if (m_owner < 0) begin
      if (v[0] != 0 && v[1] != 0) m_owner = 1 - m_ptr;
      else if (v[0] != 0)         m_owner = 0;
      else if (v[1] != 0)         m_owner = 1;
      if (m_owner >= 0) m_sel = m_owner;
      m_beats = 0;
    end else begin
      x = m_owner;
      if (v[x] != 0 && out_ready) begin
        m_beats++;
        rel = (l[x] != 0);
`ifdef ARB_BURST_LIMIT_EN
        if (m_beats >= MAX_BURST && v[1-x] != 0) rel = 1'b1;
`endif
        if (rel) begin
          m_ptr   = x;
          m_beats = 0;
          if (v[1-x] != 0)  m_owner = 1 - x;
          else if (v[x] != 0) m_owner = x;
          else              m_owner = -1;
          if (m_owner >= 0) m_sel = m_owner;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      drive_inputs();
      @(negedge clk);
      compare_and_model();
      @(posedge clk);
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      #1;
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    tick(1);
    rst = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int base, input int n,
                         input int es[8], input int ed[8]);
    chk($sformatf("%s_len", tag), 32'(log_src.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < log_src.size()) begin
        $display("%s beat %0d: src=%0d data=%0h cycle=%0d", tag, i,
                 log_src[base+i], log_data[base+i], log_cyc[base+i]);
        chk($sformatf("%s_src%0d", tag, i), 32'(log_src[base+i]), 32'(es[i]));
        chk($sformatf("%s_data%0d", tag, i), 32'(log_data[base+i]), 32'(ed[i]));
      end
    end
  endtask

  initial begin
    int base;
    int es[8];
    int ed[8];
    rst = 1'b1;
    out_ready = 1'b0;
    drive_inputs();

    // Reset held two cycles while both requesters are valid.
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1); push(1, 8'h21, 1'b1);
    tick(2);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_ready0", 32'(ready0), 32'h0);
    chk("rst_ready1", 32'(ready1), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);

    // Tie with single-beat packets: strict alternation starting at 0.
    rst = 1'b0;
    out_ready = 1'b1;
    base = log_src.size();
    tick(6);
    es = '{0, 1, 0, 1, 0, 0, 0, 0};
    ed = '{'h10, 'h20, 'h11, 'h21, 0, 0, 0, 0};
    chk_log("tie", base, 4, es, ed);

    // Packet hold: 3-beat packet from 0, then 1 with no bubble.
    do_reset();
    push(0, 8'h30, 1'b0); push(0, 8'h31, 1'b0); push(0, 8'h32, 1'b1);
    push(1, 8'h40, 1'b1);
    base = log_src.size();
    tick(6);
    es = '{0, 0, 0, 1, 0, 0, 0, 0};
    ed = '{'h30, 'h31, 'h32, 'h40, 0, 0, 0, 0};
    chk_log("hold", base, 4, es, ed);
    if (log_src.size() >= base + 4)
      chk("hold_no_bubble", 32'(log_cyc[base+3] - log_cyc[base+2]), 32'd1);

    // Backpressure mid-packet.
    do_reset();
    push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b1);
    base = log_src.size();
    tick(2);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("bp_out_data", 32'(out_data), 32'h51);
      chk("bp_ready0", 32'(ready0), 32'h0);
      chk("bp_grant", 32'(grant), 32'h1);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    tick(3);
    es = '{0, 0, 0, 0, 0, 0, 0, 0};
    ed = '{'h50, 'h51, 'h52, 0, 0, 0, 0, 0};
    chk_log("bp", base, 3, es, ed);

    // Long packet from 0 while 1 waits.
    do_reset();
    push(0, 8'h60, 1'b0); push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0);
    push(0, 8'h63, 1'b0); push(0, 8'h64, 1'b1);
    push(1, 8'h70, 1'b1);
    base = log_src.size();
    tick(9);
`ifdef ARB_BURST_LIMIT_EN
    es = '{0, 0, 1, 0, 0, 0, 0, 0};
    ed = '{'h60, 'h61, 'h70, 'h62, 'h63, 'h64, 0, 0};
`else
    es = '{0, 0, 0, 0, 0, 1, 0, 0};
    ed = '{'h60, 'h61, 'h62, 'h63, 'h64, 'h70, 0, 0};
`endif
    chk_log("burst", base, 6, es, ed);

    // Reset mid-packet: pointer moved to 0 by the first packet must be
    // restored to 1, so the next tie goes to requester 0 again.
    do_reset();
    push(0, 8'h85, 1'b1);
    push(0, 8'h80, 1'b0); push(0, 8'h81, 1'b0);
    push(0, 8'h82, 1'b0); push(0, 8'h83, 1'b1);
    base = log_src.size();
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_beats", 32'(log_src.size() - base), 32'd3);
    rst = 1'b0;
    push(1, 8'h90, 1'b1);
    tick(1);
    chk("midrst_ptr_tie", 32'(grant), 32'h1);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
